// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter that lets NREQ producers share one FIFO write port.
// A granted producer keeps the port until its last beat or MAX_BURST beats.
`timescale 1ns/1ps
module fifo_rr_arbiter #(
   parameter int NREQ      = 3,
   parameter int DW        = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst_b,
   input  logic [NREQ-1:0]      req_vld,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic [NREQ-1:0]      req_last,
   output logic [NREQ-1:0]      req_rdy,
   input  logic                 fifo_full,
   output logic                 fifo_wr_en,
   output logic [DW-1:0]        fifo_wr_data,
   output logic [1:0]           gnt_id,
   output logic                 busy,
   output logic [2:0]           beat_cnt
);

   typedef enum logic {ST_IDLE, ST_BURST} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [1:0]    r_gnt_id;
   logic [1:0]    r_last_gnt;
   logic [2:0]    r_beat_cnt;
   logic [1:0]    w_sel;
   logic          w_gnt_vld;
   logic          w_gnt_last;
   logic [DW-1:0] w_gnt_data;
   logic          w_xfer;
   logic          w_end;
   logic [DW-1:0] w_data [NREQ];
   int            w_best;
   int            w_dist;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_prod
         assign w_data[gi]  = req_data[gi*DW +: DW];
         assign req_rdy[gi] = (r_state == ST_BURST) && (r_gnt_id == 2'(gi)) && !fifo_full;
      end
   endgenerate

   // Pick the requester with the smallest upward distance from last_gnt.
   always_comb begin
      w_sel  = r_last_gnt;
      w_best = NREQ;
      w_dist = 0;
      for (int i = 0; i < NREQ; i++) begin
         w_dist = (i - int'(r_last_gnt) - 1 + 2*NREQ) % NREQ;
         if (req_vld[i] && (w_dist < w_best)) begin
            w_best = w_dist;
            w_sel  = 2'(i);
         end
      end
   end

   always_comb begin
      w_gnt_vld  = 1'b0;
      w_gnt_last = 1'b0;
      w_gnt_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_gnt_id == 2'(i)) begin
            w_gnt_vld  = req_vld[i];
            w_gnt_last = req_last[i];
            w_gnt_data = w_data[i];
         end
      end
   end

   assign w_xfer = (r_state == ST_BURST) && w_gnt_vld && !fifo_full;
   assign w_end  = w_xfer && (w_gnt_last || (r_beat_cnt == 3'(MAX_BURST - 1)));

   always_comb begin
      w_state_next = r_state;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      busy         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|req_vld) w_state_next = ST_BURST;
         end
         ST_BURST: begin
            busy         = 1'b1;
            fifo_wr_en   = w_xfer;
            fifo_wr_data = w_gnt_data;
            if (w_end) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state    <= ST_IDLE;
         r_gnt_id   <= 2'd0;
         r_last_gnt <= 2'(NREQ - 1);
         r_beat_cnt <= 3'd0;
      end else begin
         r_state <= w_state_next;
         if ((r_state == ST_IDLE) && (|req_vld)) r_gnt_id <= w_sel;
         if (w_end) begin
            r_beat_cnt <= 3'd0;
            r_last_gnt <= r_gnt_id;
         end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 3'd1;
         end
      end
   end

   assign gnt_id   = r_gnt_id;
   assign beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: expected FIFO writes are queued as
// stimulus is driven and popped by a monitor whenever the DUT writes.
`timescale 1ns/1ps
module tb_fifo_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic [2:0]  req_vld = '0;
   logic [11:0] req_data = '0;
   logic [2:0]  req_last = '0;
   logic [2:0]  req_rdy;
   logic        fifo_full = 1'b0;
   logic        fifo_wr_en;
   logic [3:0]  fifo_wr_data;
   logic [1:0]  gnt_id;
   logic        busy;
   logic [2:0]  beat_cnt;

   typedef struct {
      logic [1:0] g;
      logic [3:0] d;
   } exp_t;

   exp_t sb_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   wcyc[8];

   fifo_rr_arbiter #(.NREQ(3), .DW(4), .MAX_BURST(4)) dut (
      .clk(clk), .rst_b(rst_b),
      .req_vld(req_vld), .req_data(req_data), .req_last(req_last), .req_rdy(req_rdy),
      .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
      .gnt_id(gnt_id), .busy(busy), .beat_cnt(beat_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic push(input int g, input int d);
      sb_q.push_back('{g: 2'(g), d: 4'(d)});
   endtask

   task automatic set_data(input int p, input int v);
      req_data[p*4 +: 4] = 4'(v);
   endtask

   // Monitor: every write must match the head of the scoreboard and never hit a full FIFO.
   always @(negedge clk) begin
      if (fifo_wr_en === 1'b1) begin
         exp_t e;
         check("wr_while_full", 32'(fifo_full), 32'd0);
         check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("wr_data", 32'(fifo_wr_data), 32'(e.d));
            check("wr_gnt", 32'(gnt_id), 32'(e.g));
         end
      end
   end

   task automatic wait_wr(input string tag);
      int  n = 0;
      bit  seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         seen = (fifo_wr_en === 1'b1);
         @(posedge clk); #1;
         n++;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   // Drives n beats of base, base+1, ... from producer p; optional FIFO stall after stall_at beats.
   task automatic drive_burst(input int p, input int n, input int base, input bit lastf,
                              input int stall_at, input int stall_len);
      int k = 0;
      int cyc = 0;
      bit xf;
      for (int j = 0; j < n; j++) push(p, base + j);
      set_data(p, base);
      req_last[p] = lastf && (n == 1);
      req_vld[p]  = 1'b1;
      while (k < n && cyc < 60) begin
         @(negedge clk);
         xf = (fifo_wr_en === 1'b1);
         if (xf) begin
            wcyc[k] = cyc;
            check("beat_cnt", 32'(beat_cnt), 32'(k % 4));
         end
         @(posedge clk); #1;
         cyc++;
         if (xf) begin
            k++;
            set_data(p, base + k);
            req_last[p] = lastf && (k == n - 1);
            if (k == n) req_vld[p] = 1'b0;
            if (k == stall_at) begin
               fifo_full = 1'b1;
               repeat (stall_len) begin
                  @(negedge clk);
                  check("stall_wr_en", 32'(fifo_wr_en), 32'd0);
                  check("stall_rdy", 32'(req_rdy), 32'd0);
                  check("stall_cnt", 32'(beat_cnt), 32'(stall_at));
                  check("stall_busy", 32'(busy), 32'd1);
                  @(posedge clk); #1;
                  cyc++;
               end
               fifo_full = 1'b0;
            end
         end
      end
      check("burst_done", 32'(k), 32'(n));
      req_vld[p]  = 1'b0;
      req_last[p] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cnt[3];
      int   n;
      logic [2:0] acc;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt", 32'(gnt_id), 32'd0);
      check("rst_cnt", 32'(beat_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check("rst_rdy", 32'(req_rdy), 32'd0);
      check("rst_wr_data", 32'(fifo_wr_data), 32'd0);
      rst_b = 1'b1;
      @(posedge clk); #1;

      // All requesting, every beat last: grants 0,1,2,0 with one write every other cycle
      req_data = 12'h321;
      req_last = 3'b111;
      push(0, 1); push(1, 2); push(2, 3); push(0, 1);
      req_vld = 3'b111;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("t1_wr_en", 32'(fifo_wr_en), 32'(i % 2));
         if (i % 2 == 0) check("t1_idle_rdy", 32'(req_rdy), 32'd0);
         @(posedge clk); #1;
      end
      req_vld  = '0;
      req_last = '0;

      // Producer 1 alone, 6 beats: 4-beat burst, one idle cycle, re-grant for the rest
      drive_burst(1, 6, 1, 1'b1, -1, 0);
      check("t2_gap_b2b", 32'(wcyc[1] - wcyc[0]), 32'd1);
      check("t2_gap_regrant", 32'(wcyc[4] - wcyc[3]), 32'd2);
      check("t2_gap_cont", 32'(wcyc[5] - wcyc[4]), 32'd1);

      // Producer 2 with a 3-cycle FIFO-full stall after beat 2
      drive_burst(2, 4, 9, 1'b0, 2, 3);
      check("t3_stall_gap", 32'(wcyc[2] - wcyc[1]), 32'd4);
      check("t3_idle_after", 32'(busy), 32'd0);

      // Producer 0 holds the grant while idle; producer 1 must wait
      push(0, 5); push(0, 6); push(1, 7);
      set_data(0, 5);
      req_last = 3'b000;
      req_vld  = 3'b001;
      wait_wr("t4_w5");
      req_vld  = 3'b010;
      req_last = 3'b010;
      set_data(1, 7);
      repeat (5) begin
         @(negedge clk);
         check("t4_hold_gnt", 32'(gnt_id), 32'd0);
         check("t4_hold_busy", 32'(busy), 32'd1);
         check("t4_hold_wr", 32'(fifo_wr_en), 32'd0);
         check("t4_p1_rdy", 32'(req_rdy[1]), 32'd0);
         @(posedge clk); #1;
      end
      set_data(0, 6);
      req_vld  = 3'b011;
      req_last = 3'b011;
      wait_wr("t4_w6");
      wait_wr("t4_w7");
      req_vld  = '0;
      req_last = '0;

      // Reset during beat 2 of a producer-1 burst, then producer 0 wins
      push(1, 3);
      set_data(1, 3);
      req_vld = 3'b010;
      wait_wr("t5_beat1");
      check("t5_beat2_pending", 32'(fifo_wr_en), 32'd1);
      rst_b = 1'b0;
      #1;
      check("t5_rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_gnt", 32'(gnt_id), 32'd0);
      check("t5_rst_cnt", 32'(beat_cnt), 32'd0);
      check("t5_rst_rdy", 32'(req_rdy), 32'd0);
      check("t5_rst_data", 32'(fifo_wr_data), 32'd0);
      @(posedge clk); #1;
      rst_b    = 1'b1;
      req_data = 12'h321;
      req_last = 3'b111;
      req_vld  = 3'b111;
      push(0, 1);
      wait_wr("t5_regrant");
      req_vld  = '0;
      req_last = '0;

      // All producers busy with random FIFO-full; 3-beat bursts in order 1,2,0
      for (int r = 0; r < 2; r++)
         for (int q = 0; q < 3; q++)
            for (int j = 0; j < 3; j++) push((q + 1) % 3, 3*r + j);
      for (int p = 0; p < 3; p++) begin
         cnt[p] = 0;
         set_data(p, 0);
      end
      req_last = '0;
      req_vld  = 3'b111;
      n = 0;
      while (sb_q.size() > 0 && n < 300) begin
         fifo_full = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         acc = req_vld & req_rdy;
         @(posedge clk); #1;
         for (int p = 0; p < 3; p++) begin
            if (acc[p]) begin
               cnt[p]++;
               set_data(p, cnt[p]);
               req_last[p] = (cnt[p] % 3 == 2);
            end
         end
         n++;
      end
      req_vld   = '0;
      req_last  = '0;
      fifo_full = 1'b0;
      check("rand_drain", 32'(sb_q.size()), 32'd0);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
